// File: rtl/world_pkg.sv
// Shared constants, world-entry layout, helpers and FSM encoding for the cube picker.
package world_pkg;

  localparam int COORD_WIDTH  = 32;
  localparam int WORLD_BITS   = 7;
  localparam int WORLD_SIZE   = 128;
  localparam int NORMAL_WIDTH = 2;
  localparam int READ_LATENCY = 3;

  // Q16.16 reference values.
  localparam logic [COORD_WIDTH-1:0] ONE  = 32'h0001_0000;
  localparam logic [COORD_WIDTH-1:0] HALF = 32'h0000_8000;
  localparam int FRAC_BITS = $clog2(ONE);

  localparam logic signed [COORD_WIDTH-1:0] Q_ZERO = 32'sh0000_0000;
  localparam logic signed [COORD_WIDTH-1:0] Q_MAX  = 32'sh7FFF_FFFF;

  // World entry layout: {valid, x, y, z}, each coordinate a signed integer cube centre.
  localparam int CUBE_BITS   = COORD_WIDTH - FRAC_BITS;
  localparam int ENTRY_WIDTH = 3 * CUBE_BITS + 1;
  localparam int VALID_BIT   = 3 * CUBE_BITS;
  localparam int X_LSB       = 2 * CUBE_BITS;
  localparam int X_MSB       = X_LSB + CUBE_BITS - 1;
  localparam int Y_LSB       = CUBE_BITS;
  localparam int Y_MSB       = Y_LSB + CUBE_BITS - 1;
  localparam int Z_LSB       = 0;
  localparam int Z_MSB       = CUBE_BITS - 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DIFF = 3'd2,
    S_DOT  = 3'd3,
    S_PERP = 3'd4,
    S_CMP  = 3'd5,
    S_NEXT = 3'd6,
    S_DONE = 3'd7
  } state_t;

  // Integer cube coordinate to Q16.16: sign-extend then shift left by the fraction width.
  function automatic logic signed [COORD_WIDTH-1:0] cube_to_q(input logic [CUBE_BITS-1:0] c);
    return {c, {FRAC_BITS{1'b0}}};
  endfunction

  // Magnitude of a signed Q16.16 value (the most negative value stays large and never passes a bound).
  function automatic logic [COORD_WIDTH-1:0] abs_q(input logic signed [COORD_WIDTH-1:0] v);
    logic [COORD_WIDTH-1:0] r;
    if (v[COORD_WIDTH-1]) begin
      r = -v;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Entry-face normal component: opposite sign of the ray direction, 0 when the axis is unused.
  function automatic logic [NORMAL_WIDTH-1:0] neg_sign(input logic signed [COORD_WIDTH-1:0] v);
    logic [NORMAL_WIDTH-1:0] r;
    if (v[COORD_WIDTH-1]) begin
      r = NORMAL_WIDTH'(1'b1);
    end else if (v != Q_ZERO) begin
      r = {NORMAL_WIDTH{1'b1}};
    end else begin
      r = {NORMAL_WIDTH{1'b0}};
    end
    return r;
  endfunction

endpackage

// File: rtl/fx_mul.sv
// Combinational signed Q16.16 multiply: full-width product, middle word returned.
module fx_mul
  import world_pkg::*;
#(
  parameter int W = world_pkg::COORD_WIDTH
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] p
);

  logic signed [2*W-1:0] full;

  assign full = (2*W)'(a) * (2*W)'(b);
  // Drop the low fraction bits and keep one word: bits [W+FRAC_BITS-1:FRAC_BITS].
  assign p = W'(full >>> FRAC_BITS);

endmodule

// File: rtl/cube_picker.sv
// Scans the world memory once per request and reports the nearest valid cube the
// camera's forward ray passes through, plus the face normal it enters by.
module cube_picker
  import world_pkg::*;
#(
  parameter int COORD_WIDTH  = world_pkg::COORD_WIDTH,
  parameter int WORLD_BITS   = world_pkg::WORLD_BITS,
  parameter int WORLD_SIZE   = world_pkg::WORLD_SIZE,
  parameter int NORMAL_WIDTH = world_pkg::NORMAL_WIDTH,
  parameter int READ_LATENCY = world_pkg::READ_LATENCY
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic                                start,
  input  logic signed [COORD_WIDTH-1:0]       cam_x,
  input  logic signed [COORD_WIDTH-1:0]       cam_y,
  input  logic signed [COORD_WIDTH-1:0]       cam_z,
  input  logic [2:0][COORD_WIDTH-1:0]         forward_vec,
  input  logic [3*COORD_WIDTH/2:0]            world_read,
  output logic [WORLD_BITS-1:0]               world_read_addr,
  output logic [WORLD_BITS-1:0]               looked_at_cube,
  output logic [2:0][NORMAL_WIDTH-1:0]        looked_at_normal,
  output logic                                hit,
  output logic                                busy,
  output logic                                done
);

  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(READ_LATENCY - 1);
  localparam logic [WORLD_BITS-1:0] ADDR_LAST = WORLD_BITS'(WORLD_SIZE - 1);

  state_t                          state_r, state_s;
  logic [CNT_W-1:0]                cnt_r, cnt_s;
  logic [WORLD_BITS-1:0]           addr_r, addr_s;
  logic [WORLD_BITS-1:0]           best_addr_r, best_addr_s;
  logic [WORLD_BITS-1:0]           cube_r, cube_s;
  logic signed [COORD_WIDTH-1:0]   cam_r [3];
  logic signed [COORD_WIDTH-1:0]   cam_s [3];
  logic signed [COORD_WIDTH-1:0]   fwd_r [3];
  logic signed [COORD_WIDTH-1:0]   fwd_s [3];
  logic signed [COORD_WIDTH-1:0]   d_r [3];
  logic signed [COORD_WIDTH-1:0]   d_s [3];
  logic signed [COORD_WIDTH-1:0]   e_r [3];
  logic signed [COORD_WIDTH-1:0]   e_s [3];
  logic signed [COORD_WIDTH-1:0]   mul_a [3];
  logic signed [COORD_WIDTH-1:0]   mul_p [3];
  logic signed [COORD_WIDTH-1:0]   t_r, t_s;
  logic signed [COORD_WIDTH-1:0]   best_t_r, best_t_s;
  logic [CUBE_BITS-1:0]            cube_c_r [3];
  logic [CUBE_BITS-1:0]            cube_c_s [3];
  logic                            ent_valid_r, ent_valid_s;
  logic                            found_r, found_s;
  logic                            hit_r, hit_s;
  logic                            busy_r, busy_s;
  logic                            done_r, done_s;
  logic [2:0][NORMAL_WIDTH-1:0]    normal_r, normal_s, face_s;
  logic [COORD_WIDTH-1:0]          fwd_abs_s [3];
  logic [1:0]                      axis_s;
  logic                            near_s;

  assign world_read_addr  = addr_r;
  assign looked_at_cube   = cube_r;
  assign looked_at_normal = normal_r;
  assign hit              = hit_r;
  assign busy             = busy_r;
  assign done             = done_r;

  // Share the three multipliers: d*f while forming t, then t*f while forming the residual.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      mul_a[i] = (state_r == S_PERP) ? t_r : d_r[i];
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_mul
    fx_mul #(.W(COORD_WIDTH)) u_fx_mul (
      .a (mul_a[g]),
      .b (fwd_r[g]),
      .p (mul_p[g])
    );
  end

  // Ray passes within half a cube of the centre on every axis.
  always_comb begin
    near_s = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (abs_q(e_r[i]) > HALF) begin
        near_s = 1'b0;
      end else begin
        near_s = near_s;
      end
    end
  end

  // Entry face: dominant axis of the ray (ties go to x, then y), facing back toward the camera.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      fwd_abs_s[i] = abs_q(fwd_r[i]);
    end
    if ((fwd_abs_s[2] > fwd_abs_s[0]) && (fwd_abs_s[2] > fwd_abs_s[1])) begin
      axis_s = 2'd2;
    end else if (fwd_abs_s[1] > fwd_abs_s[0]) begin
      axis_s = 2'd1;
    end else begin
      axis_s = 2'd0;
    end
    for (int i = 0; i < 3; i++) begin
      if (axis_s == 2'(i)) begin
        face_s[i] = neg_sign(fwd_r[i]);
      end else begin
        face_s[i] = {NORMAL_WIDTH{1'b0}};
      end
    end
  end

  // Next-state and datapath update for the scan sequence; every register holds by default.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    addr_s      = addr_r;
    best_addr_s = best_addr_r;
    cube_s      = cube_r;
    t_s         = t_r;
    best_t_s    = best_t_r;
    ent_valid_s = ent_valid_r;
    found_s     = found_r;
    hit_s       = hit_r;
    busy_s      = busy_r;
    done_s      = 1'b0;
    normal_s    = normal_r;
    for (int i = 0; i < 3; i++) begin
      cam_s[i]    = cam_r[i];
      fwd_s[i]    = fwd_r[i];
      d_s[i]      = d_r[i];
      e_s[i]      = e_r[i];
      cube_c_s[i] = cube_c_r[i];
    end

    case (state_r)
      S_IDLE: begin
        if (start) begin
          cam_s[0] = cam_x;
          cam_s[1] = cam_y;
          cam_s[2] = cam_z;
          for (int i = 0; i < 3; i++) begin
            fwd_s[i] = forward_vec[i];
          end
          best_t_s = Q_MAX;
          found_s  = 1'b0;
          addr_s   = {WORLD_BITS{1'b0}};
          cnt_s    = {CNT_W{1'b0}};
          busy_s   = 1'b1;
          state_s  = S_WAIT;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_WAIT: begin
        // The read data for addr_r is valid on the last wait cycle.
        if (cnt_r == CNT_LAST) begin
          ent_valid_s = world_read[VALID_BIT];
          cube_c_s[0] = world_read[X_MSB:X_LSB];
          cube_c_s[1] = world_read[Y_MSB:Y_LSB];
          cube_c_s[2] = world_read[Z_MSB:Z_LSB];
          cnt_s       = {CNT_W{1'b0}};
          state_s     = S_DIFF;
        end else begin
          cnt_s = cnt_r + CNT_W'(1'b1);
        end
      end
      S_DIFF: begin
        // Invalid entries still walk every step so the scan time never depends on data.
        for (int i = 0; i < 3; i++) begin
          d_s[i] = cube_to_q(cube_c_r[i]) - cam_r[i];
        end
        state_s = S_DOT;
      end
      S_DOT: begin
        t_s     = mul_p[0] + mul_p[1] + mul_p[2];
        state_s = S_PERP;
      end
      S_PERP: begin
        for (int i = 0; i < 3; i++) begin
          e_s[i] = d_r[i] - mul_p[i];
        end
        state_s = S_CMP;
      end
      S_CMP: begin
        // Strictly closer only, so equal distances keep the earlier address.
        if (ent_valid_r && (t_r > Q_ZERO) && near_s && (t_r < best_t_r)) begin
          best_t_s    = t_r;
          best_addr_s = addr_r;
          found_s     = 1'b1;
        end else begin
          found_s = found_r;
        end
        state_s = S_NEXT;
      end
      S_NEXT: begin
        if (addr_r < ADDR_LAST) begin
          addr_s  = addr_r + WORLD_BITS'(1'b1);
          cnt_s   = {CNT_W{1'b0}};
          state_s = S_WAIT;
        end else begin
          state_s = S_DONE;
        end
      end
      S_DONE: begin
        hit_s = found_r;
        if (found_r) begin
          cube_s   = best_addr_r;
          normal_s = face_s;
        end else begin
          cube_s   = {WORLD_BITS{1'b0}};
          normal_s = {3*NORMAL_WIDTH{1'b0}};
        end
        done_s  = 1'b1;
        busy_s  = 1'b0;
        state_s = S_IDLE;
      end
      default: begin
        busy_s  = 1'b0;
        state_s = S_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and output registers; reset abandons any scan without a done pulse.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt_r       <= {CNT_W{1'b0}};
      addr_r      <= {WORLD_BITS{1'b0}};
      best_addr_r <= {WORLD_BITS{1'b0}};
      cube_r      <= {WORLD_BITS{1'b0}};
      t_r         <= Q_ZERO;
      best_t_r    <= Q_MAX;
      ent_valid_r <= 1'b0;
      found_r     <= 1'b0;
      hit_r       <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      normal_r    <= {3*NORMAL_WIDTH{1'b0}};
      for (int i = 0; i < 3; i++) begin
        cam_r[i]    <= Q_ZERO;
        fwd_r[i]    <= Q_ZERO;
        d_r[i]      <= Q_ZERO;
        e_r[i]      <= Q_ZERO;
        cube_c_r[i] <= {CUBE_BITS{1'b0}};
      end
    end else begin
      cnt_r       <= cnt_s;
      addr_r      <= addr_s;
      best_addr_r <= best_addr_s;
      cube_r      <= cube_s;
      t_r         <= t_s;
      best_t_r    <= best_t_s;
      ent_valid_r <= ent_valid_s;
      found_r     <= found_s;
      hit_r       <= hit_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      normal_r    <= normal_s;
      cam_r       <= cam_s;
      fwd_r       <= fwd_s;
      d_r         <= d_s;
      e_r         <= e_s;
      cube_c_r    <= cube_c_s;
    end
  end

endmodule
